// File: rtl/stream_serializer.sv
// Captures a full layer output vector on one pulse and drains it LANES elements per beat over
// valid/ready through a two-slot ping-pong buffer. Define SERIALIZE_ARGMAX_EN for argmax outputs.
module stream_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_NEURON = 30,
  parameter int unsigned LANES      = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             par_valid,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] par_data,
  output logic                             par_ready,
  output logic                             ser_valid,
  output logic [LANES*DATA_WIDTH-1:0]      ser_data,
  output logic                             ser_last,
  input  logic                             ser_ready,
  output logic                             overflow,
  input  logic                             clear_ovf,
  output logic                             busy
`ifdef SERIALIZE_ARGMAX_EN
  ,
  output logic [$clog2(NUM_NEURON)-1:0]    argmax_idx,
  output logic                             argmax_valid
`endif
);

  localparam int unsigned VecW  = NUM_NEURON * DATA_WIDTH;
  localparam int unsigned BeatW = LANES * DATA_WIDTH;
  localparam int unsigned Beats = NUM_NEURON / LANES;
  localparam int unsigned BcW   = (Beats > 1) ? $clog2(Beats) : 1;

  if ((NUM_NEURON % LANES) != 0) begin : g_lanes_check
    $error("stream_serializer: LANES must divide NUM_NEURON");
  end

  logic [VecW-1:0]  r_slot [2];
  logic [1:0]       r_full;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [BcW-1:0]   r_bc;
  logic             r_ovf;

  logic             w_cap;
  logic             w_drop;
  logic             w_hs;
  logic [BeatW-1:0] w_beat;

  assign par_ready = ~(r_full[0] & r_full[1]);
  assign busy      = r_full[0] | r_full[1];
  assign overflow  = r_ovf;

  assign ser_valid = r_full[r_rd_ptr];
  assign w_beat    = r_slot[r_rd_ptr][r_bc*BeatW +: BeatW];
  // Gate data so it reads zero whenever no beat is offered, including straight out of reset.
  assign ser_data  = ser_valid ? w_beat : '0;
  assign ser_last  = ser_valid & (r_bc == BcW'(Beats - 1));

  assign w_cap  = par_valid & par_ready;
  assign w_drop = par_valid & ~par_ready;
  assign w_hs   = ser_valid & ser_ready;

  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_slot[r_wr_ptr] <= par_data;
    end
  end

  // A capture always targets a free slot and a release always a full one, so the two
  // updates to r_full below never touch the same bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_bc     <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_cap) begin
        r_full[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_hs) begin
        if (ser_last) begin
          r_bc             <= '0;
          r_full[r_rd_ptr] <= 1'b0;
          r_rd_ptr         <= ~r_rd_ptr;
        end else begin
          r_bc <= r_bc + BcW'(1);
        end
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clear_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef SERIALIZE_ARGMAX_EN
  localparam int unsigned IdxW = $clog2(NUM_NEURON);

  logic signed [DATA_WIDTH-1:0] r_max;
  logic signed [DATA_WIDTH-1:0] w_best_val;
  logic [IdxW-1:0]              r_max_idx;
  logic [IdxW-1:0]              w_best_idx;
  logic [IdxW-1:0]              r_am_idx;
  logic                         r_am_valid;

  // Strict greater-than keeps the earliest index on ties; beat 0 restarts the search.
  always_comb begin
    w_best_val = r_max;
    w_best_idx = r_max_idx;
    for (int j = 0; j < LANES; j++) begin
      if (((r_bc == '0) && (j == 0)) ||
          ($signed(w_beat[j*DATA_WIDTH +: DATA_WIDTH]) > w_best_val)) begin
        w_best_val = $signed(w_beat[j*DATA_WIDTH +: DATA_WIDTH]);
        w_best_idx = IdxW'(r_bc * LANES + j);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_max      <= '0;
      r_max_idx  <= '0;
      r_am_idx   <= '0;
      r_am_valid <= 1'b0;
    end else begin
      r_am_valid <= w_hs & ser_last;
      if (w_hs) begin
        r_max     <= w_best_val;
        r_max_idx <= w_best_idx;
        if (ser_last) begin
          r_am_idx <= w_best_idx;
        end
      end
    end
  end

  assign argmax_idx   = r_am_idx;
  assign argmax_valid = r_am_valid;
`endif

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer: one LANES=1 and one LANES=2 instance on shared stimulus.
module tb_stream_serializer;

  localparam int unsigned DW = 16;
  localparam int unsigned NN = 4;

  logic            clk;
  logic            rstn;
  logic            par_valid;
  logic [NN*DW-1:0] par_data;
  logic            ser_ready;
  logic            clear_ovf;

  logic            par_ready1, ser_valid1, ser_last1, overflow1, busy1;
  logic [DW-1:0]   ser_data1;
  logic            par_ready2, ser_valid2, ser_last2, overflow2, busy2;
  logic [2*DW-1:0] ser_data2;
`ifdef SERIALIZE_ARGMAX_EN
  logic [1:0]      am_idx1, am_idx2;
  logic            am_valid1, am_valid2;
`endif

  int checks   = 0;
  int failures = 0;
  int idx;

  stream_serializer #(.DATA_WIDTH(DW), .NUM_NEURON(NN), .LANES(1)) u_dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .par_valid (par_valid),
    .par_data  (par_data),
    .par_ready (par_ready1),
    .ser_valid (ser_valid1),
    .ser_data  (ser_data1),
    .ser_last  (ser_last1),
    .ser_ready (ser_ready),
    .overflow  (overflow1),
    .clear_ovf (clear_ovf),
    .busy      (busy1)
`ifdef SERIALIZE_ARGMAX_EN
    ,
    .argmax_idx   (am_idx1),
    .argmax_valid (am_valid1)
`endif
  );

  stream_serializer #(.DATA_WIDTH(DW), .NUM_NEURON(NN), .LANES(2)) u_dut2 (
    .clk       (clk),
    .rstn      (rstn),
    .par_valid (par_valid),
    .par_data  (par_data),
    .par_ready (par_ready2),
    .ser_valid (ser_valid2),
    .ser_data  (ser_data2),
    .ser_last  (ser_last2),
    .ser_ready (ser_ready),
    .overflow  (overflow2),
    .clear_ovf (clear_ovf),
    .busy      (busy2)
`ifdef SERIALIZE_ARGMAX_EN
    ,
    .argmax_idx   (am_idx2),
    .argmax_valid (am_valid2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, ser_valid1, 1'b0);
    check({tag, "_last"},  ser_last1,  1'b0);
    check({tag, "_data"},  ser_data1,  16'h0);
    check({tag, "_ovf"},   overflow1,  1'b0);
    check({tag, "_busy"},  busy1,      1'b0);
    check({tag, "_pready"}, par_ready1, 1'b1);
    check({tag, "_valid2"}, ser_valid2, 1'b0);
    check({tag, "_data2"},  ser_data2,  32'h0);
    check({tag, "_ovf2"},   overflow2,  1'b0);
    check({tag, "_busy2"},  busy2,      1'b0);
    check({tag, "_pready2"}, par_ready2, 1'b1);
`ifdef SERIALIZE_ARGMAX_EN
    check({tag, "_amv"}, am_valid1, 1'b0);
    check({tag, "_ami"}, am_idx1,   2'd0);
`endif
  endtask

  initial begin
    rstn      = 1'b0;
    par_valid = 1'b0;
    par_data  = '0;
    ser_ready = 1'b0;
    clear_ovf = 1'b0;
    tick();
    tick();
    check_reset("rst");
    rstn = 1'b1;
    tick();

    // Basic drain (LANES=1) and lane grouping (LANES=2), elements 1,2,3,4
    ser_ready = 1'b1;
    par_valid = 1'b1;
    par_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    tick();
    par_valid = 1'b0;
    check("d0_valid", ser_valid1, 1'b1);
    check("d0_data",  ser_data1,  16'd1);
    check("d0_last",  ser_last1,  1'b0);
    check("d0_busy",  busy1,      1'b1);
    check("l0_data",  ser_data2,  32'h0002_0001);
    check("l0_last",  ser_last2,  1'b0);
    tick();
    check("d1_data",  ser_data1,  16'd2);
    check("d1_last",  ser_last1,  1'b0);
    check("l1_data",  ser_data2,  32'h0004_0003);
    check("l1_last",  ser_last2,  1'b1);
    tick();
    check("d2_data",  ser_data1,  16'd3);
    check("l2_valid", ser_valid2, 1'b0);
    check("l2_busy",  busy2,      1'b0);
    tick();
    check("d3_data",  ser_data1,  16'd4);
    check("d3_last",  ser_last1,  1'b1);

    // Capture into the free slot on the same edge the last beat releases the other
    par_valid = 1'b1;
    par_data  = {16'd40, 16'd30, 16'd20, 16'd10};
    tick();
    par_valid = 1'b0;
    check("sw_valid", ser_valid1, 1'b1);
    check("sw_data",  ser_data1,  16'd10);
    check("sw_last",  ser_last1,  1'b0);

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    idx = 0;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      check("bp_valid", ser_valid1, 1'b1);
      check("bp_data",  ser_data1,  64'((idx + 1) * 10));
      check("bp_last",  ser_last1,  idx == 3);
      ser_ready = (k % 3 == 0);
      tick();
      if (ser_ready) idx++;
    end
    check("bp_count", idx, 64'd4);
    check("bp_empty", ser_valid1, 1'b0);
    check("bp_busy",  busy1,      1'b0);

    // Ping-pong and overflow with the sink stalled
    ser_ready = 1'b0;
    tick();
    par_valid = 1'b1;
    par_data  = {16'h14, 16'h13, 16'h12, 16'h11};
    tick();
    check("pp1_pready", par_ready1, 1'b1);
    check("pp1_busy",   busy1,      1'b1);
    check("pp1_data",   ser_data1,  16'h11);
    par_data = {16'h24, 16'h23, 16'h22, 16'h21};
    tick();
    check("pp2_pready", par_ready1, 1'b0);
    check("pp2_ovf",    overflow1,  1'b0);
    par_data = {16'h34, 16'h33, 16'h32, 16'h31};
    tick();
    check("ovf_set",    overflow1,  1'b1);
    check("ovf_pready", par_ready1, 1'b0);
    clear_ovf = 1'b1;
    tick();
    check("ovf_prio",   overflow1,  1'b1);
    par_valid = 1'b0;
    tick();
    clear_ovf = 1'b0;
    check("ovf_clr",    overflow1,  1'b0);
    check("pp_hold",    ser_data1,  16'h11);

    // Release: A then B, no bubble; a drop on A's last beat is not rescued
    ser_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_valid", ser_valid1, 1'b1);
      check("pp_data",  ser_data1,  64'(16'h11 + (i / 4) * 16 + (i % 4)));
      check("pp_last",  ser_last1,  (i % 4) == 3);
      if (i == 3) begin
        par_valid = 1'b1;
        par_data  = {16'h44, 16'h43, 16'h42, 16'h41};
      end else begin
        par_valid = 1'b0;
      end
      tick();
    end
    par_valid = 1'b0;
    check("pp_empty",  ser_valid1, 1'b0);
    check("pp_norescue", overflow1, 1'b1);
    check("pp_busy",   busy1,      1'b0);

    // Reset in the middle of a drain
    par_valid = 1'b1;
    par_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    tick();
    par_valid = 1'b0;
    check("rm_b0", ser_data1, 16'd1);
    tick();
    check("rm_b1", ser_data1, 16'd2);
    rstn = 1'b0;
    #1;
    check_reset("rm");
    tick();
    rstn = 1'b1;
    par_valid = 1'b1;
    par_data  = {16'd40, 16'd30, 16'd20, 16'd10};
    tick();
    par_valid = 1'b0;
    check("ra_valid", ser_valid1, 1'b1);
    check("ra_data0", ser_data1,  16'd10);
    tick();
    check("ra_data1", ser_data1,  16'd20);
    tick();
    tick();
    tick();
    check("ra_empty", ser_valid1, 1'b0);

`ifdef SERIALIZE_ARGMAX_EN
    // Elements -5, 7, 7, 2: tie between 1 and 2 resolves to 1
    par_valid = 1'b1;
    par_data  = {16'd2, 16'd7, 16'd7, 16'hFFFB};
    tick();
    par_valid = 1'b0;
    check("am1_idle", am_valid1, 1'b0);
    tick();
    tick();
    check("am2_valid", am_valid2, 1'b1);
    check("am2_idx",   am_idx2,   2'd1);
    tick();
    check("am2_pulse", am_valid2, 1'b0);
    check("am2_hold",  am_idx2,   2'd1);
    check("am1_wait",  am_valid1, 1'b0);
    tick();
    check("am1_valid", am_valid1, 1'b1);
    check("am1_idx",   am_idx1,   2'd1);
    tick();
    check("am1_pulse", am_valid1, 1'b0);
    check("am1_hold",  am_idx1,   2'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Parametrised successor to the per-layer parallel-to-serial stage between neuron layers.
- Captures a full layer output vector (NUM_NEURON elements) on a single valid pulse and drains it as LANES elements per beat on a valid/ready stream.
- Adds backpressure, a two-slot ping-pong buffer so a new vector can land while the previous one drains, a last-beat marker, and sticky overflow reporting.
- Sits after each LayerN instance and before the next layer, or before the AXI-Lite readout path.

Parameters:
- DATA_WIDTH, 16, width of one neuron output element.
- NUM_NEURON, 30, elements per captured vector.
- LANES, 1, elements per output beat; must divide NUM_NEURON (elaboration error otherwise).

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- par_valid  in  1  one-cycle pulse: par_data holds a complete vector.
- par_data  in  NUM_NEURON*DATA_WIDTH  vector; element i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- par_ready  out  1  at least one buffer slot is free.
- ser_valid  out  1  output beat valid.
- ser_data  out  LANES*DATA_WIDTH  beat; lane j = element (beat*LANES + j).
- ser_last  out  1  final beat of a vector; qualified by ser_valid.
- ser_ready  in  1  downstream accepts the beat.
- overflow  out  1  sticky: a vector was dropped.
- clear_ovf  in  1  synchronous clear of overflow.
- busy  out  1  any slot full.

Behaviour:
- Reset: all of the following are cleared, and any partially drained vector is discarded.
  - Both slots empty; wr_ptr = rd_ptr = 0; beat counter = 0.
  - Outputs: ser_valid = 0, ser_last = 0, ser_data = 0, overflow = 0, busy = 0, par_ready = 1.
- Slot state: full[1:0] registers. par_ready = ~(full[0] & full[1]), derived from registered state only; there is no combinational path from ser_ready.
- Capture:
  - When par_valid & par_ready, store par_data into slot wr_ptr, set full[wr_ptr], toggle wr_ptr.
  - When par_valid & ~par_ready, drop the vector, set overflow, and leave the slots unchanged.
  - A free-on-last-beat in the same cycle does not rescue the vector.
- Drain:
  - ser_valid = full[rd_ptr].
  - ser_data is the lane group selected by beat counter bc (0 .. NUM_NEURON/LANES-1) from slot rd_ptr.
  - ser_last = ser_valid & (bc == NUM_NEURON/LANES-1).
- Handshake:
  - On ser_valid & ser_ready: if not last, bc++.
  - On the last beat: bc <= 0, clear full[rd_ptr], toggle rd_ptr.
  - ser_data and ser_valid hold stable while ser_valid & ~ser_ready.
- Latency: capture at edge N gives ser_valid = 1 after edge N (first beat visible in cycle N+1) when the slot was the current read slot. Vectors drain in strict arrival order.
- Simultaneous capture into the free slot and last-beat release of the other slot: both take effect in the same edge.
- Throughput: one beat per cycle with ser_ready held high; back-to-back vectors drain with no bubble.
- overflow:
  - Set has priority over clear_ovf in the same cycle.
  - Once set, it holds until clear_ovf or reset.
- busy = full[0] | full[1].
- Width: data is passed unmodified; no sign handling except in the optional feature.

Optional Feature:
- Macro: SERIALIZE_ARGMAX_EN.
- Defined: adds outputs argmax_idx (width $clog2(NUM_NEURON)) and argmax_valid.
  - Running comparison over signed elements as beats handshake.
  - Ties resolve to the lowest index.
  - argmax_valid pulses for one cycle on the cycle after the last-beat handshake; argmax_idx holds until the next result.
  - Reset value 0 for both.
  - This replaces a separate maxFinder after the final layer.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic drain: NUM_NEURON=4, LANES=1, vector {4,3,2,1} (element0 = 1), ser_ready = 1 -> beats 1,2,3,4 in consecutive cycles starting the cycle after capture; ser_last only on 4; busy drops after the last beat.
- Lanes: NUM_NEURON=4, LANES=2, same vector -> two beats {2,1} then {4,3}; ser_last on the second beat.
- Backpressure: ser_ready toggles 1,0,0,1,... -> ser_data stable during stalls; order preserved; no duplicate or lost beat.
- Ping-pong and overflow: three par_valid pulses 1 cycle apart with ser_ready = 0.
  - Pulses 1 and 2 are accepted; par_ready = 0 after the second.
  - Pulse 3 sets overflow.
  - Release ser_ready -> vectors 1 then 2 drain; clear_ovf clears overflow.
- Reset mid-drain: assert rstn = 0 after beat 1 of 4 -> all outputs go to reset values; a new vector after reset drains from element 0.
- With SERIALIZE_ARGMAX_EN: vector {-5, 7, 7, 2} (element order) -> argmax_idx = 1 with argmax_valid = 1 for one cycle after the last beat.
